// File: rtl/vcfg_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl and holds the
// architectural vl/vtype/vlmax state, with a valid/ready issue and writeback handshake.
module vcfg_unit #(
    parameter int XLEN      = 32,
    parameter int VLEN      = 16384,
    parameter int ELEN      = 64,
    parameter int SPLIT_AVL = 0,
    parameter int VL_BITS   = $clog2(VLEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        insn,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic [XLEN-1:0]    rs2_val,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         rd_addr,
    output logic [XLEN-1:0]    rd_data,
    output logic [VL_BITS-1:0] vl,
    output logic [XLEN-1:0]    vtype,
    output logic [VL_BITS-1:0] vlmax,
    output logic               busy
);

    localparam logic [6:0]         OPC_V     = 7'b1010111;
    localparam int                 ELEN_LOG2 = $clog2(ELEN);
    localparam int                 MAX_VSEW  = ELEN_LOG2 - 3;
    localparam logic [VL_BITS-1:0] VLEN_W    = VL_BITS'(VLEN);
    localparam logic [XLEN-1:0]    VILL_W    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [31:0]        insn_r;
    logic [XLEN-1:0]    rs1_r;
    logic [XLEN-1:0]    rs2_r;
    logic [VL_BITS-1:0] vl_r;
    logic [VL_BITS-1:0] vlmax_r;
    logic [XLEN-1:0]    vtype_r;
    logic               out_valid_r;
    logic [4:0]         rd_addr_r;
    logic [XLEN-1:0]    rd_data_r;

    logic               is_vcfg_s;
    logic               is_ivli_s;
    logic [XLEN-1:0]    new_vtype_s;
    logic [2:0]         vlmul_s;
    logic [2:0]         vsew_s;
    logic               bad_vtype_s;
    logic               keep_vl_s;
    logic               illegal_s;
    logic [VL_BITS-1:0] vlmax_base_s;
    logic [VL_BITS-1:0] vlmax_raw_s;
    logic [XLEN-1:0]    vlmax_x_s;
    logic [XLEN-1:0]    avl_s;
    logic [XLEN-1:0]    vl_sel_s;
    logic [XLEN-1:0]    res_vtype_s;
    logic [XLEN-1:0]    res_vl_s;
    logic [VL_BITS-1:0] res_vlmax_s;

    // Decode the captured word and compute the candidate vtype, vlmax and vl
    always_comb begin
        is_vcfg_s   = 1'b0;
        is_ivli_s   = 1'b0;
        new_vtype_s = {XLEN{1'b0}};
        if (insn_r[6:0] == OPC_V && insn_r[14:12] == 3'b111) begin
            if (insn_r[31] == 1'b0) begin
                is_vcfg_s   = 1'b1;
                new_vtype_s = XLEN'(insn_r[30:20]);
            end else if (insn_r[31:30] == 2'b11) begin
                is_vcfg_s   = 1'b1;
                is_ivli_s   = 1'b1;
                new_vtype_s = XLEN'(insn_r[29:20]);
            end else if (insn_r[31:25] == 7'b1000000) begin
                is_vcfg_s   = 1'b1;
                new_vtype_s = rs2_r;
            end else begin
                is_vcfg_s   = 1'b0;
            end
        end else begin
            is_vcfg_s = 1'b0;
        end

        vlmul_s = new_vtype_s[2:0];
        vsew_s  = new_vtype_s[5:3];

        // Fractional check: SEW > ELEN*LMUL  <=>  3 + vsew + (8 - vlmul) > log2(ELEN)
        bad_vtype_s = new_vtype_s[XLEN-1]
                    | (|new_vtype_s[XLEN-2:8])
                    | (vlmul_s == 3'b100)
                    | (int'(vsew_s) > MAX_VSEW)
                    | (vlmul_s[2] && ((int'(vsew_s) + 32'sd11 - int'(vlmul_s)) > ELEN_LOG2));

        vlmax_base_s = VLEN_W >> ({1'b0, vsew_s} + 4'd3);
        if (vlmul_s[2] == 1'b0) begin
            vlmax_raw_s = vlmax_base_s << vlmul_s;
        end else begin
            vlmax_raw_s = vlmax_base_s >> (4'd8 - {1'b0, vlmul_s});
        end
        vlmax_x_s = XLEN'(vlmax_raw_s);

        keep_vl_s = 1'b0;
        if (is_ivli_s) begin
            avl_s = XLEN'(insn_r[19:15]);
        end else if (insn_r[19:15] != 5'd0) begin
            avl_s = rs1_r;
        end else if (insn_r[11:7] != 5'd0) begin
            avl_s = {XLEN{1'b1}};
        end else begin
            avl_s     = XLEN'(vl_r);
            keep_vl_s = 1'b1;
        end

        illegal_s = bad_vtype_s | (keep_vl_s && (vlmax_raw_s != vlmax_r));

        if (avl_s <= vlmax_x_s) begin
            vl_sel_s = avl_s;
        end else if (SPLIT_AVL != 0 && avl_s < (vlmax_x_s << 1)) begin
            vl_sel_s = (avl_s + {{(XLEN-1){1'b0}}, 1'b1}) >> 1;
        end else begin
            vl_sel_s = vlmax_x_s;
        end

        if (illegal_s) begin
            res_vtype_s = VILL_W;
            res_vl_s    = {XLEN{1'b0}};
            res_vlmax_s = {VL_BITS{1'b0}};
        end else begin
            res_vtype_s = new_vtype_s;
            res_vl_s    = vl_sel_s;
            res_vlmax_s = vlmax_raw_s;
        end
    end

    // Handshake FSM with architectural state commit on the CALC edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            insn_r      <= 32'd0;
            rs1_r       <= {XLEN{1'b0}};
            rs2_r       <= {XLEN{1'b0}};
            vl_r        <= {VL_BITS{1'b0}};
            vlmax_r     <= {VL_BITS{1'b0}};
            vtype_r     <= VILL_W;
            out_valid_r <= 1'b0;
            rd_addr_r   <= 5'd0;
            rd_data_r   <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        insn_r  <= insn;
                        rs1_r   <= rs1_val;
                        rs2_r   <= rs2_val;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    if (is_vcfg_s) begin
                        vtype_r     <= res_vtype_s;
                        vl_r        <= res_vl_s[VL_BITS-1:0];
                        vlmax_r     <= res_vlmax_s;
                        rd_addr_r   <= insn_r[11:7];
                        rd_data_r   <= res_vl_s;
                        out_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign rd_addr   = rd_addr_r;
    assign rd_data   = rd_data_r;
    assign vl        = vl_r;
    assign vtype     = vtype_r;
    assign vlmax     = vlmax_r;

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed bench for vcfg_unit: default instance plus a SPLIT_AVL=1 instance on shared stimulus.
module tb_vcfg_unit;

    localparam int XLEN    = 32;
    localparam int VL_BITS = 15;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        insn;
    logic [XLEN-1:0]    rs1_val;
    logic [XLEN-1:0]    rs2_val;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         rd_addr;
    logic [XLEN-1:0]    rd_data;
    logic [VL_BITS-1:0] vl;
    logic [XLEN-1:0]    vtype;
    logic [VL_BITS-1:0] vlmax;
    logic               busy;

    logic               s_in_ready;
    logic               s_out_valid;
    logic [4:0]         s_rd_addr;
    logic [XLEN-1:0]    s_rd_data;
    logic [VL_BITS-1:0] s_vl;
    logic [XLEN-1:0]    s_vtype;
    logic [VL_BITS-1:0] s_vlmax;
    logic               s_busy;

    int err_cnt = 0;
    int chk_cnt = 0;

    vcfg_unit u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .insn(insn), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .vl(vl), .vtype(vtype), .vlmax(vlmax), .busy(busy)
    );

    vcfg_unit #(.SPLIT_AVL(1)) u_dut_split (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .insn(insn), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .out_valid(s_out_valid), .out_ready(out_ready), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .vl(s_vl), .vtype(s_vtype), .vlmax(s_vlmax), .busy(s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vsetvli_w(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vsetivli_w(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vsetvl_w(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    // Present one word for a single accept edge; returns at the negedge of cycle T+2
    task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        insn     = w;
        rs1_val  = a;
        rs2_val  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("calc_no_ov", {31'd0, out_valid}, 32'd0);
        check_val("calc_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] e_vl, input logic [31:0] e_vtype,
                               input logic [31:0] e_vlmax, input logic [4:0] e_rd);
        check_val({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_vl"}, {17'd0, vl}, e_vl);
        check_val({tag, "_vtype"}, vtype, e_vtype);
        check_val({tag, "_vlmax"}, {17'd0, vlmax}, e_vlmax);
        check_val({tag, "_rd"}, {27'd0, rd_addr}, {27'd0, e_rd});
        check_val({tag, "_rdata"}, rd_data, e_vl);
    endtask

    task automatic retire();
        @(negedge clk);
        for (int i = 0; i < 8 && !in_ready; i++) @(negedge clk);
        check_val("back_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        insn      = 32'd0;
        rs1_val   = 32'd0;
        rs2_val   = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check_val("rst_vl", {17'd0, vl}, 32'd0);
        check_val("rst_vtype", vtype, 32'h8000_0000);
        check_val("rst_vlmax", {17'd0, vlmax}, 32'd0);
        check_val("rst_ov", {31'd0, out_valid}, 32'd0);
        check_val("rst_rd", {27'd0, rd_addr}, 32'd0);
        check_val("rst_rdata", rd_data, 32'd0);
        check_val("rst_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);

        issue(vsetvli_w(5'd5, 5'd6, 11'h011), 32'd100, 32'd0);
        expect_resp("e32m2_100", 32'd100, 32'h11, 32'd1024, 5'd5);
        check_val("split_100", {17'd0, s_vl}, 32'd100);
        retire();

        issue(vsetvli_w(5'd5, 5'd6, 11'h011), 32'd5000, 32'd0);
        expect_resp("e32m2_5000", 32'd1024, 32'h11, 32'd1024, 5'd5);
        check_val("split_5000", {17'd0, s_vl}, 32'd1024);
        retire();

        issue(vsetvli_w(5'd5, 5'd6, 11'h011), 32'd1500, 32'd0);
        expect_resp("e32m2_1500", 32'd1024, 32'h11, 32'd1024, 5'd5);
        check_val("split_1500_vl", {17'd0, s_vl}, 32'd750);
        check_val("split_1500_rdata", s_rd_data, 32'd750);
        check_val("split_1500_ov", {31'd0, s_out_valid}, 32'd1);
        retire();

        issue(vsetvli_w(5'd5, 5'd6, 11'h011), 32'd2048, 32'd0);
        check_val("split_2048", {17'd0, s_vl}, 32'd1024);
        check_val("plain_2048", {17'd0, vl}, 32'd1024);
        retire();

        issue(vsetvli_w(5'd1, 5'd0, 11'h010), 32'd7, 32'd0);
        expect_resp("avl_max", 32'd512, 32'h10, 32'd512, 5'd1);
        check_val("split_avl_max", {17'd0, s_vl}, 32'd512);
        retire();

        issue(vsetvli_w(5'd4, 5'd6, 11'h005), 32'd1000, 32'd0);
        expect_resp("e8mf8", 32'd256, 32'h05, 32'd256, 5'd4);
        retire();

        issue(vsetvli_w(5'd4, 5'd6, 11'h01F), 32'd1000, 32'd0);
        expect_resp("e64mf2", 32'd0, 32'h8000_0000, 32'd0, 5'd4);
        retire();

        issue(vsetvl_w(5'd7, 5'd6, 5'd2), 32'd50, 32'h100);
        expect_resp("vsetvl_rsv", 32'd0, 32'h8000_0000, 32'd0, 5'd7);
        retire();

        issue(vsetvl_w(5'd7, 5'd6, 5'd2), 32'd3000, 32'hC9);
        expect_resp("vsetvl_tama", 32'd2048, 32'hC9, 32'd2048, 5'd7);
        check_val("split_3000", {17'd0, s_vl}, 32'd1500);
        retire();

        issue(vsetivli_w(5'd8, 5'd31, 10'h000), 32'd0, 32'd0);
        expect_resp("ivli31", 32'd31, 32'h00, 32'd2048, 5'd8);
        retire();

        issue(vsetvli_w(5'd0, 5'd0, 11'h009), 32'd123, 32'd0);
        expect_resp("keep_same", 32'd31, 32'h09, 32'd2048, 5'd0);
        check_val("split_keep", {17'd0, s_vl}, 32'd31);
        retire();

        issue(vsetvli_w(5'd0, 5'd0, 11'h008), 32'd123, 32'd0);
        expect_resp("keep_diff", 32'd0, 32'h8000_0000, 32'd0, 5'd0);
        retire();

        // Backpressure: response held, second request refused
        out_ready = 1'b0;
        issue(vsetvli_w(5'd9, 5'd6, 11'h000), 32'd10, 32'd0);
        check_val("bp_ov", {31'd0, out_valid}, 32'd1);
        check_val("bp_rdata", rd_data, 32'd10);
        insn     = vsetvli_w(5'd9, 5'd6, 11'h000);
        rs1_val  = 32'd77;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("bp_hold_ov", {31'd0, out_valid}, 32'd1);
            check_val("bp_hold_rdata", rd_data, 32'd10);
            check_val("bp_hold_rd", {27'd0, rd_addr}, 32'd9);
            check_val("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release_ov", {31'd0, out_valid}, 32'd0);
        check_val("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check_val("bp_second_dropped", {17'd0, vl}, 32'd10);
        @(negedge clk);
        check_val("bp_idle", {31'd0, busy}, 32'd0);

        // Reset while in CALC discards the instruction
        insn     = vsetvli_w(5'd3, 5'd6, 11'h000);
        rs1_val  = 32'd20;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("rstcalc_ov", {31'd0, out_valid}, 32'd0);
        check_val("rstcalc_vl", {17'd0, vl}, 32'd0);
        check_val("rstcalc_vtype", vtype, 32'h8000_0000);
        check_val("rstcalc_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check_val("rstcalc_no_resp", {31'd0, out_valid}, 32'd0);

        issue(vsetvli_w(5'd10, 5'd6, 11'h011), 32'd300, 32'd0);
        expect_resp("pre_nop", 32'd300, 32'h11, 32'd1024, 5'd10);
        retire();

        // Non-vector word is swallowed without a response
        @(negedge clk);
        insn     = 32'h0000_0013;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("nop_busy", {31'd0, busy}, 32'd1);
        check_val("nop_calc_ov", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_val("nop_ready", {31'd0, in_ready}, 32'd1);
        check_val("nop_ov", {31'd0, out_valid}, 32'd0);
        check_val("nop_vl", {17'd0, vl}, 32'd300);
        check_val("nop_vtype", vtype, 32'h11);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
